// File: rtl/multi_clock_gen_pkg.sv
// Shared types and constants for the multi-channel derived clock generator.
package multi_clock_gen_pkg;

    localparam int unsigned CNT_W_DEF  = 8;
    localparam int unsigned MIN_PERIOD = 2;
    localparam int unsigned LFSR_W     = 8;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 8'hA5;

    // Channel configuration at the default counter width.
    typedef struct packed {
        logic [CNT_W_DEF-1:0] period;
        logic [CNT_W_DEF-1:0] high;
        logic [CNT_W_DEF-1:0] phase;
    } ch_cfg_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PHASE = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } ch_state_e;

    // Fibonacci LFSR step, taps 8,6,5,4.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

endpackage

// File: rtl/clock_gen_ch.sv
// One derived-clock channel: shadow/active config, channel FSM and cycle counter.
module clock_gen_ch
    import multi_clock_gen_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_cfg_we,
    input  logic [CNT_W-1:0] i_cfg_period,
    input  logic [CNT_W-1:0] i_cfg_high,
    input  logic [CNT_W-1:0] i_cfg_phase,
    input  logic             i_jitter,
    output logic             o_clk_out,
    output logic             o_tick,
    output logic             o_running
);

    typedef struct packed {
        logic [CNT_W-1:0] period;
        logic [CNT_W-1:0] high;
        logic [CNT_W-1:0] phase;
    } cfg_t;

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_PHASE = PHASE;
    localparam logic [1:0] S_RUN   = RUN;
    localparam logic [1:0] S_DRAIN = DRAIN;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ext;
    cfg_t             r_shd;
    cfg_t             r_act;
    logic             r_clk_out;
    logic             r_tick;
    logic             r_running;

    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_ext_nxt;
    cfg_t             w_act_nxt;
    logic             w_last;
    logic             w_extend;
    logic             w_active_nxt;
    logic             w_clk_nxt;
    logic             w_tick_nxt;
    logic             w_running_nxt;

    // Shadow config: written by accepted configuration writes only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shd.period <= CNT_W'(MIN_PERIOD);
            r_shd.high   <= CNT_W'(1);
            r_shd.phase  <= '0;
        end else if (i_cfg_we) begin
            r_shd.period <= i_cfg_period;
            r_shd.high   <= i_cfg_high;
            r_shd.phase  <= i_cfg_phase;
        end
    end

    // State, counter, active config and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_ext        <= 1'b0;
            r_act.period <= CNT_W'(MIN_PERIOD);
            r_act.high   <= CNT_W'(1);
            r_act.phase  <= '0;
            r_clk_out    <= 1'b0;
            r_tick       <= 1'b0;
            r_running    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_ext     <= w_ext_nxt;
            r_act     <= w_act_nxt;
            r_clk_out <= w_clk_nxt;
            r_tick    <= w_tick_nxt;
            r_running <= w_running_nxt;
        end
    end

    // Next state/counter; outputs are decoded from next values so they register cleanly.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_ext_nxt     = r_ext;
        w_act_nxt     = r_act;
        w_active_nxt  = 1'b0;
        w_clk_nxt     = 1'b0;
        w_tick_nxt    = 1'b0;
        w_running_nxt = 1'b0;
        w_last        = (r_cnt == (r_act.period - CNT_W'(1)));
        w_extend      = i_jitter && !r_ext && (r_act.period >= CNT_W'(3));

        case (r_state)
            S_IDLE: begin
                if (i_start && !i_stop) begin
                    w_act_nxt   = r_shd;
                    w_cnt_nxt   = '0;
                    w_ext_nxt   = 1'b0;
                    w_state_nxt = (r_shd.phase == '0) ? S_RUN : S_PHASE;
                end
            end
            S_PHASE: begin
                if (i_stop) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == (r_act.phase - CNT_W'(1))) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_RUN, S_DRAIN: begin
                if (w_last && w_extend) begin
                    // Hold the last (low) count one extra cycle.
                    w_ext_nxt = 1'b1;
                    if (i_stop) begin
                        w_state_nxt = S_DRAIN;
                    end
                end else if (w_last) begin
                    // Period boundary: the only point the active config may change.
                    w_cnt_nxt   = '0;
                    w_ext_nxt   = 1'b0;
                    w_act_nxt   = r_shd;
                    w_state_nxt = (i_stop || (r_state == S_DRAIN)) ? S_IDLE : S_RUN;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    if (i_stop) begin
                        w_state_nxt = S_DRAIN;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        w_active_nxt  = (w_state_nxt == S_RUN) || (w_state_nxt == S_DRAIN);
        w_clk_nxt     = w_active_nxt && (w_cnt_nxt < w_act_nxt.high);
        w_tick_nxt    = w_active_nxt && (w_cnt_nxt == '0);
        w_running_nxt = (w_state_nxt != S_IDLE);
    end

    assign o_clk_out = r_clk_out;
    assign o_tick    = r_tick;
    assign o_running = r_running;

endmodule

// File: rtl/multi_clock_gen.sv
// Multi-channel derived clock generator: config decode/validation, error pulse, channel array.
// Optional period jitter is enabled by defining MULTI_CLOCK_GEN_JITTER_EN.
module multi_clock_gen
    import multi_clock_gen_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = CNT_W_DEF,
    parameter int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [CNT_W-1:0]  cfg_high,
    input  logic [CNT_W-1:0]  cfg_phase,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] running,
    output logic              cfg_err
);

    logic              w_cfg_ok;
    logic [NUM_CH-1:0] w_we;
    logic [NUM_CH-1:0] w_jitter;
    logic              r_cfg_err;

    // A write is legal only if it describes a real clock on an existing channel.
    always_comb begin
        w_cfg_ok = (cfg_period >= CNT_W'(MIN_PERIOD))
                && (cfg_high != '0)
                && (cfg_high < cfg_period)
                && (cfg_phase < cfg_period)
                && (32'(cfg_ch) < NUM_CH);
    end

    // One-cycle error pulse in the cycle after a rejected write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= cfg_we && !w_cfg_ok;
        end
    end

    assign cfg_err = r_cfg_err;

`ifdef MULTI_CLOCK_GEN_JITTER_EN
    logic [LFSR_W-1:0] r_lfsr;

    // Free-running jitter source.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_jit
        assign w_jitter[c] = r_lfsr[c % LFSR_W];
    end
`else
    assign w_jitter = '0;
`endif

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign w_we[c] = cfg_we && w_cfg_ok && (cfg_ch == CH_W'(c));

        clock_gen_ch #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .i_start      (start),
            .i_stop       (stop),
            .i_cfg_we     (w_we[c]),
            .i_cfg_period (cfg_period),
            .i_cfg_high   (cfg_high),
            .i_cfg_phase  (cfg_phase),
            .i_jitter     (w_jitter[c]),
            .o_clk_out    (clk_out[c]),
            .o_tick       (tick[c]),
            .o_running    (running[c])
        );
    end

endmodule

// File: tb/tb_multi_clock_gen.sv
// Self-checking bench for multi_clock_gen: waveform-queue reference model plus directed windows.
module tb_multi_clock_gen;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned CH_W   = 2;
    localparam int unsigned VW     = 3 * NUM_CH + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              stop;
    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_period;
    logic [CNT_W-1:0]  cfg_high;
    logic [CNT_W-1:0]  cfg_phase;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] running;
    logic              cfg_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // One expected output cycle of a channel.
    typedef struct packed {
        logic ph;
        logic last;
        logic tk;
        logic ck;
    } smp_t;

    smp_t        q [NUM_CH][$];
    bit          drn [NUM_CH];
    int          sh_p [NUM_CH];
    int          sh_h [NUM_CH];
    int          sh_ph [NUM_CH];
    logic [VW-1:0] exp_v;

    always #5 clk = ~clk;

    multi_clock_gen #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W),
        .CH_W   (CH_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_period (cfg_period),
        .cfg_high   (cfg_high),
        .cfg_phase  (cfg_phase),
        .clk_out    (clk_out),
        .tick       (tick),
        .running    (running),
        .cfg_err    (cfg_err)
    );

    function automatic bit cfg_valid(input int p, input int h, input int ph);
        return (p >= 2) && (h >= 1) && (h <= p - 1) && (ph < p);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            q[c].delete();
            drn[c]   = 1'b0;
            sh_p[c]  = 2;
            sh_h[c]  = 1;
            sh_ph[c] = 0;
        end
        exp_v = '0;
    endtask

    // Append one whole period of waveform built from the channel's current shadow.
    task automatic push_period(input int c);
        smp_t s;
        for (int i = 0; i < sh_p[c]; i++) begin
            s.ph   = 1'b0;
            s.last = (i == sh_p[c] - 1);
            s.tk   = (i == 0);
            s.ck   = (i < sh_h[c]);
            q[c].push_back(s);
        end
    endtask

    // Advance the model across one clock edge with the given inputs.
    task automatic model_edge(input bit st, input bit sp, input bit we,
                              input int ch, input int p, input int h, input int ph);
        smp_t cur;
        smp_t s;
        logic [NUM_CH-1:0] e_ck;
        logic [NUM_CH-1:0] e_tk;
        logic [NUM_CH-1:0] e_run;
        for (int c = 0; c < NUM_CH; c++) begin
            if (q[c].size() == 0) begin
                if (st && !sp) begin
                    for (int i = 0; i < sh_ph[c]; i++) begin
                        s = '0;
                        s.ph = 1'b1;
                        q[c].push_back(s);
                    end
                    push_period(c);
                end
            end else begin
                cur = q[c].pop_front();
                if (cur.ph) begin
                    if (sp) q[c].delete();
                end else begin
                    if (sp) drn[c] = 1'b1;
                    if (cur.last) begin
                        if (drn[c]) begin
                            drn[c] = 1'b0;
                            q[c].delete();
                        end else begin
                            push_period(c);
                        end
                    end
                end
            end
        end
        if (we && cfg_valid(p, h, ph)) begin
            sh_p[ch]  = p;
            sh_h[ch]  = h;
            sh_ph[ch] = ph;
        end
        for (int c = 0; c < NUM_CH; c++) begin
            e_run[c] = (q[c].size() != 0);
            e_ck[c]  = e_run[c] ? q[c][0].ck : 1'b0;
            e_tk[c]  = e_run[c] ? q[c][0].tk : 1'b0;
        end
        exp_v = {e_run, e_tk, e_ck, (we && !cfg_valid(p, h, ph))};
    endtask

    // Drive one cycle of stimulus, clock it, update the model.
    task automatic step(input bit st, input bit sp, input bit we,
                        input int ch, input int p, input int h, input int ph);
        @(negedge clk);
        start      = st;
        stop       = sp;
        cfg_we     = we;
        cfg_ch     = CH_W'(ch);
        cfg_period = CNT_W'(p);
        cfg_high   = CNT_W'(h);
        cfg_phase  = CNT_W'(ph);
        @(posedge clk);
        model_edge(st, sp, we, ch, p, h, ph);
        #1;
        start  = 1'b0;
        stop   = 1'b0;
        cfg_we = 1'b0;
        cyc++;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0; stop = 1'b0; cfg_we = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({running, tick, clk_out, cfg_err} !== '0) begin
            errors++;
            $display("FAIL reset_hold got=%h exp=0", {running, tick, clk_out, cfg_err});
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            idle();
            checks++;
            if ({running, tick, clk_out, cfg_err} !== exp_v) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc, {running, tick, clk_out, cfg_err}, exp_v);
            end
        end
    endtask

    task automatic test_default_start();
        logic [NUM_CH-1:0] want;
        do_reset();
        step(1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        for (int k = 1; k <= 8; k++) begin
            want = (k % 2 == 1) ? '1 : '0;
            checks++;
            if (clk_out !== want || tick !== want || running !== '1) begin
                errors++;
                $display("FAIL default_toggle k=%0d clk=%h tick=%h run=%h want_clk=%h", k, clk_out, tick, running, want);
            end
            checks++;
            if ({running, tick, clk_out, cfg_err} !== exp_v) begin
                errors++;
                $display("FAIL default_model cyc=%0d got=%h exp=%h", cyc, {running, tick, clk_out, cfg_err}, exp_v);
            end
            idle();
        end
    endtask

    task automatic test_phase();
        logic w0;
        logic w1;
        do_reset();
        step(1'b0, 1'b0, 1'b1, 0, 10, 3, 0);
        step(1'b0, 1'b0, 1'b1, 1, 10, 5, 5);
        step(1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        for (int k = 1; k <= 20; k++) begin
            w0 = ((k >= 1 && k <= 3) || (k >= 11 && k <= 13));
            w1 = (k >= 6 && k <= 10) || (k >= 16 && k <= 20);
            checks++;
            if (clk_out[0] !== w0 || clk_out[1] !== w1) begin
                errors++;
                $display("FAIL phase_window k=%0d ch0=%b ch1=%b want ch0=%b ch1=%b", k, clk_out[0], clk_out[1], w0, w1);
            end
            checks++;
            if ({running, tick, clk_out, cfg_err} !== exp_v) begin
                errors++;
                $display("FAIL phase_model cyc=%0d got=%h exp=%h", cyc, {running, tick, clk_out, cfg_err}, exp_v);
            end
            idle();
        end
    endtask

    task automatic test_cfg_err();
        do_reset();
        step(1'b0, 1'b0, 1'b1, 2, 4, 0, 0);
        checks++;
        if (cfg_err !== 1'b1) begin
            errors++;
            $display("FAIL cfg_err_pulse got=%b exp=1", cfg_err);
        end
        idle();
        checks++;
        if (cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL cfg_err_single got=%b exp=0", cfg_err);
        end
        step(1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        for (int k = 1; k <= 6; k++) begin
            checks++;
            if (clk_out[2] !== logic'(k % 2 == 1)) begin
                errors++;
                $display("FAIL cfg_err_default k=%0d got=%b exp=%b", k, clk_out[2], (k % 2 == 1));
            end
            checks++;
            if ({running, tick, clk_out, cfg_err} !== exp_v) begin
                errors++;
                $display("FAIL cfg_err_model cyc=%0d got=%h exp=%h", cyc, {running, tick, clk_out, cfg_err}, exp_v);
            end
            idle();
        end
    endtask

    task automatic test_reconfig();
        logic w;
        do_reset();
        step(1'b0, 1'b0, 1'b1, 0, 4, 2, 0);
        step(1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        for (int k = 1; k <= 16; k++) begin
            w = (k <= 4) ? (k <= 2) : (((k - 5) % 6) < 3);
            checks++;
            if (clk_out[0] !== w) begin
                errors++;
                $display("FAIL reconfig_wave k=%0d got=%b exp=%b", k, clk_out[0], w);
            end
            checks++;
            if ({running, tick, clk_out, cfg_err} !== exp_v) begin
                errors++;
                $display("FAIL reconfig_model cyc=%0d got=%h exp=%h", cyc, {running, tick, clk_out, cfg_err}, exp_v);
            end
            step(1'b0, 1'b0, (k == 2), 0, 6, 3, 0);
        end
    endtask

    task automatic test_stop_drain();
        do_reset();
        step(1'b0, 1'b0, 1'b1, 0, 8, 4, 0);
        step(1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        for (int k = 1; k <= 14; k++) begin
            checks++;
            if (clk_out[0] !== logic'(k <= 4) || running[0] !== logic'(k <= 8)) begin
                errors++;
                $display("FAIL stop_drain k=%0d clk=%b run=%b exp clk=%b run=%b", k, clk_out[0], running[0], (k <= 4), (k <= 8));
            end
            checks++;
            if ({running, tick, clk_out, cfg_err} !== exp_v) begin
                errors++;
                $display("FAIL stop_model cyc=%0d got=%h exp=%h", cyc, {running, tick, clk_out, cfg_err}, exp_v);
            end
            step(1'b0, (k == 2), 1'b0, 0, 0, 0, 0);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        step(1'b0, 1'b0, 1'b1, 0, 6, 2, 0);
        step(1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        checks++;
        if (clk_out[0] !== 1'b1) begin
            errors++;
            $display("FAIL async_pre got=%b exp=1", clk_out[0]);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({running, tick, clk_out, cfg_err} !== '0) begin
            errors++;
            $display("FAIL async_drop got=%h exp=0", {running, tick, clk_out, cfg_err});
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        idle();
        step(1'b1, 1'b0, 1'b0, 0, 0, 0, 0);
        for (int k = 1; k <= 6; k++) begin
            checks++;
            if (clk_out[0] !== logic'(k % 2 == 1)) begin
                errors++;
                $display("FAIL async_defaults k=%0d got=%b exp=%b", k, clk_out[0], (k % 2 == 1));
            end
            checks++;
            if ({running, tick, clk_out, cfg_err} !== exp_v) begin
                errors++;
                $display("FAIL async_model cyc=%0d got=%h exp=%h", cyc, {running, tick, clk_out, cfg_err}, exp_v);
            end
            idle();
        end
    endtask

    task automatic test_random();
        bit st;
        bit sp;
        bit we;
        int ch;
        int p;
        int h;
        int ph;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            st = ($urandom_range(0, 9) == 0);
            sp = ($urandom_range(0, 24) == 0);
            we = ($urandom_range(0, 3) == 0);
            ch = int'($urandom_range(0, NUM_CH - 1));
            p  = int'($urandom_range(0, 12));
            h  = int'($urandom_range(0, p));
            ph = int'($urandom_range(0, p));
            step(st, sp, we, ch, p, h, ph);
            checks++;
            if ({running, tick, clk_out, cfg_err} !== exp_v) begin
                errors++;
                $display("FAIL random cyc=%0d got=%h exp=%h", cyc, {running, tick, clk_out, cfg_err}, exp_v);
            end
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; stop = 1'b0; cfg_we = 1'b0;
        cfg_ch = '0; cfg_period = '0; cfg_high = '0; cfg_phase = '0;
        model_reset();
        test_reset();
        test_default_start();
        test_phase();
        test_cfg_err();
        test_reconfig();
        test_stop_drain();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
